// File: rtl/mux4_rr_arbiter_if.sv
// Bus between four requesters and the round-robin mux arbiter.
// MUX4_ARB_LOCK_EN adds the lock (hold-extend) signal.
interface mux4_rr_arbiter_if #(
    parameter int unsigned DW = 1
);
    logic [3:0]    req;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] d3;
    logic [DW-1:0] d4;
`ifdef MUX4_ARB_LOCK_EN
    logic          lock;
`endif
    logic [3:0]    gnt;
    logic          I0;
    logic          I1;
    logic [DW-1:0] q;
    logic          q_valid;

`ifdef MUX4_ARB_LOCK_EN
    modport master (output req, d1, d2, d3, d4, lock,
                    input  gnt, I0, I1, q, q_valid);
    modport slave  (input  req, d1, d2, d3, d4, lock,
                    output gnt, I0, I1, q, q_valid);
`else
    modport master (output req, d1, d2, d3, d4,
                    input  gnt, I0, I1, q, q_valid);
    modport slave  (input  req, d1, d2, d3, d4,
                    output gnt, I0, I1, q, q_valid);
`endif
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a 4-to-1 mux with bounded hold time and registered data output.
// Optional MUX4_ARB_LOCK_EN: lock suspends the hold timeout while the owner keeps requesting.
module mux4_rr_arbiter #(
    parameter int unsigned DW       = 1,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux4_rr_arbiter_if.slave      bus
);
    localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_sel;
    logic [1:0]    r_ptr;
    logic [HW-1:0] r_hold;
    logic [3:0]    r_gnt;
    logic [DW-1:0] r_q;
    logic          r_qv;

    logic [1:0]    w_sel_nxt;
    logic [1:0]    w_ptr_nxt;
    logic [HW-1:0] w_hold_nxt;
    logic [3:0]    w_gnt_nxt;
    logic [3:0]    w_req;
    logic          w_any_req;
    logic          w_own_req;
    logic          w_lock_hold;
    logic          w_at_max;
    logic          w_release;
    logic [1:0]    w_pick;
    logic [DW-1:0] w_d [4];

    // First requesting lane after base, wrapping; base itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        rr_pick = base;
        for (int i = 4; i >= 1; i--) begin
            idx = base + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign w_req     = bus.req;
    assign w_d[0]    = bus.d1;
    assign w_d[1]    = bus.d2;
    assign w_d[2]    = bus.d3;
    assign w_d[3]    = bus.d4;
    assign w_any_req = |w_req;
    assign w_own_req = w_req[r_sel];
    assign w_at_max  = (r_hold == HW'(MAX_HOLD - 1));
`ifdef MUX4_ARB_LOCK_EN
    assign w_lock_hold = bus.lock & w_own_req;
`else
    assign w_lock_hold = 1'b0;
`endif
    assign w_release = !w_own_req || (w_at_max && !w_lock_hold);
    assign w_pick    = rr_pick(w_req, (r_state == S_IDLE) ? r_ptr : r_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_nxt = S_GRANT;
            S_GRANT: if (w_release && !w_any_req) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next owner, pointer, hold count and grant; sel keeps its value when going idle.
    always_comb begin
        w_sel_nxt  = r_sel;
        w_ptr_nxt  = r_ptr;
        w_hold_nxt = r_hold;
        w_gnt_nxt  = r_gnt;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_sel_nxt  = w_pick;
                    w_hold_nxt = '0;
                    w_gnt_nxt  = 4'(1) << w_pick;
                end
            end
            S_GRANT: begin
                if (!w_release) begin
                    if (!w_lock_hold && !w_at_max) w_hold_nxt = r_hold + HW'(1);
                end else begin
                    w_ptr_nxt  = r_sel;
                    w_hold_nxt = '0;
                    if (w_any_req) begin
                        w_sel_nxt = w_pick;
                        w_gnt_nxt = 4'(1) << w_pick;
                    end else begin
                        w_gnt_nxt = '0;
                    end
                end
            end
            default: w_gnt_nxt = '0;
        endcase
    end

    // Data of an owner that drops its request on this edge is not captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel  <= 2'd0;
            r_ptr  <= 2'd3;
            r_hold <= '0;
            r_gnt  <= 4'd0;
            r_q    <= '0;
            r_qv   <= 1'b0;
        end else begin
            r_sel  <= w_sel_nxt;
            r_ptr  <= w_ptr_nxt;
            r_hold <= w_hold_nxt;
            r_gnt  <= w_gnt_nxt;
            r_qv   <= |r_gnt;
            if ((r_state == S_GRANT) && w_own_req) r_q <= w_d[r_sel];
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.I0      = r_sel[0];
    assign bus.I1      = r_sel[1];
    assign bus.q       = r_q;
    assign bus.q_valid = r_qv;
endmodule
